// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, funct codes, ALU operations and the
// layout of the ID/EX control bundle, used by decode, hazard logic and EX.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Bit positions inside the flat 9-bit ex_ctrl bus seen by EX.
    localparam int CTRL_ILLEGAL   = 8;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_REGWRITE  = 4;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_W         = 9;

    typedef struct packed {
        logic    illegal;
        logic    branch;
        logic    mem_write;
        logic    mem_read;
        logic    reg_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    // Register-file read with same-cycle WB bypass; $zero always reads 0.
    function automatic logic [31:0] sel_operand(
        input logic [4:0]  rreg,
        input logic [31:0] rdata,
        input logic        wb_we,
        input logic [4:0]  wb_wra,
        input logic [31:0] wb_wrd
    );
        logic [31:0] val;
        if (rreg == 5'd0) begin
            val = 32'd0;
        end else if (wb_we && (wb_wra == rreg)) begin
            val = wb_wrd;
        end else begin
            val = rdata;
        end
        return val;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of IF/ID inputs, WB write-back, register-file read and ID/EX outputs.
interface id_ex_stage_if;
    import pipe_pkg::*;

    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_RegWrite;
    logic [4:0]  wb_wra;
    logic [31:0] wb_wrd;

    logic [4:0]  rreg1;
    logic [4:0]  rreg2;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc4;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wra;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output in_valid, in_instr, in_pc4, flush, rd1, rd2,
               wb_RegWrite, wb_wra, wb_wrd,
        input  rreg1, rreg2, stall, ex_valid, ex_pc4, ex_a, ex_b,
               ex_imm, ex_rs, ex_rt, ex_wra, ex_ctrl
    );

    modport slave (
        input  in_valid, in_instr, in_pc4, flush, rd1, rd2,
               wb_RegWrite, wb_wra, wb_wrd,
        output rreg1, rreg2, stall, ex_valid, ex_pc4, ex_a, ex_b,
               ex_imm, ex_rs, ex_rt, ex_wra, ex_ctrl
    );

endinterface

// File: rtl/id_ex_stage_decode.sv
// Combinational instruction decode: control bundle, destination register,
// extended immediate and whether rt is a real source operand.
module id_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  wra,
    output logic [31:0] imm,
    output logic        uses_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       illegal;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    always_comb begin
        ctrl    = '0;
        wra     = 5'd0;
        imm     = {{16{instr[15]}}, instr[15:0]};
        uses_rt = 1'b0;
        illegal = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                uses_rt        = 1'b1;
                wra            = rd;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                wra            = rt;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                wra            = rt;
                imm            = {16'd0, instr[15:0]};
            end
            OP_LW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                wra            = rt;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                uses_rt     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal instructions travel down the pipe as a marked no-op.
        if (illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            wra          = 5'd0;
        end

        if (wra == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID stage with load-use hazard detection, WB bypass and the ID/EX register.
module id_ex_stage
    import pipe_pkg::*;
(
    input logic           clk,
    input logic           nrst,
    id_ex_stage_if.slave  bus
);

    ctrl_t       dec_ctrl;
    logic [4:0]  dec_wra;
    logic [31:0] dec_imm;
    logic        dec_uses_rt;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hz;

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc4_q,   ex_pc4_d;
    logic [31:0] ex_a_q,     ex_a_d;
    logic [31:0] ex_b_q,     ex_b_d;
    logic [31:0] ex_imm_q,   ex_imm_d;
    logic [4:0]  ex_rs_q,    ex_rs_d;
    logic [4:0]  ex_rt_q,    ex_rt_d;
    logic [4:0]  ex_wra_q,   ex_wra_d;
    ctrl_t       ex_ctrl_q,  ex_ctrl_d;

    id_decode u_decode (
        .instr   (bus.in_instr),
        .ctrl    (dec_ctrl),
        .wra     (dec_wra),
        .imm     (dec_imm),
        .uses_rt (dec_uses_rt)
    );

    assign rs = bus.in_instr[25:21];
    assign rt = bus.in_instr[20:16];

    // A load in EX whose target is read by the ID instruction needs one bubble.
    assign hz = bus.in_valid && ex_valid_q && ex_ctrl_q.mem_read &&
                (ex_wra_q != 5'd0) &&
                ((ex_wra_q == rs) || ((ex_wra_q == rt) && dec_uses_rt));

    always_comb begin
        ex_valid_d = 1'b0;
        ex_pc4_d   = 32'd0;
        ex_a_d     = 32'd0;
        ex_b_d     = 32'd0;
        ex_imm_d   = 32'd0;
        ex_rs_d    = 5'd0;
        ex_rt_d    = 5'd0;
        ex_wra_d   = 5'd0;
        ex_ctrl_d  = '0;

        if (!bus.flush && !hz && bus.in_valid) begin
            ex_valid_d = 1'b1;
            ex_pc4_d   = bus.in_pc4;
            ex_a_d     = sel_operand(rs, bus.rd1, bus.wb_RegWrite, bus.wb_wra, bus.wb_wrd);
            ex_b_d     = sel_operand(rt, bus.rd2, bus.wb_RegWrite, bus.wb_wra, bus.wb_wrd);
            ex_imm_d   = dec_imm;
            ex_rs_d    = rs;
            ex_rt_d    = rt;
            ex_wra_d   = dec_wra;
            ex_ctrl_d  = dec_ctrl;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ex_valid_q <= 1'b0;
            ex_pc4_q   <= 32'd0;
            ex_a_q     <= 32'd0;
            ex_b_q     <= 32'd0;
            ex_imm_q   <= 32'd0;
            ex_rs_q    <= 5'd0;
            ex_rt_q    <= 5'd0;
            ex_wra_q   <= 5'd0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_wra_q   <= ex_wra_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign bus.rreg1    = rs;
    assign bus.rreg2    = rt;
    assign bus.stall    = hz && !bus.flush;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc4   = ex_pc4_q;
    assign bus.ex_a     = ex_a_q;
    assign bus.ex_b     = ex_b_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_rs    = ex_rs_q;
    assign bus.ex_rt    = ex_rt_q;
    assign bus.ex_wra   = ex_wra_q;
    assign bus.ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wra;
        logic [8:0]  ctrl;
    } exp_t;

    exp_t mdl;
    logic exp_stall;
    logic stall_seen;
    int   chk_cnt;
    int   pass_cnt;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] w;
        w = 32'd0;
        w[25:21] = rs[4:0];
        w[20:16] = rt[4:0];
        w[15:11] = rd[4:0];
        w[5:0]   = fn;
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
        logic [31:0] w;
        w = {op, rs[4:0], rt[4:0], im};
        return w;
    endfunction

    function automatic exp_t dut_vec();
        exp_t v;
        v.valid = bus.ex_valid;
        v.pc4   = bus.ex_pc4;
        v.a     = bus.ex_a;
        v.b     = bus.ex_b;
        v.imm   = bus.ex_imm;
        v.rs    = bus.ex_rs;
        v.rt    = bus.ex_rt;
        v.wra   = bus.ex_wra;
        v.ctrl  = bus.ex_ctrl;
        return v;
    endfunction

    // Reference: what a freshly decoded instruction looks like in ID/EX.
    function automatic exp_t model_load(input logic [31:0] ins, input logic [31:0] pc4,
                                        input logic [31:0] r1, input logic [31:0] r2,
                                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int op, fn, alu;
        logic src, mr, mw, rw, br, ill;
        logic [4:0] dst;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        alu = 0; src = 0; mr = 0; mw = 0; rw = 0; br = 0; ill = 0; dst = 0;
        e.imm = {{16{ins[15]}}, ins[15:0]};
        if (op == 0) begin
            rw = 1; dst = ins[15:11];
            if      (fn == 'h20) alu = 0;
            else if (fn == 'h22) alu = 1;
            else if (fn == 'h24) alu = 2;
            else if (fn == 'h25) alu = 3;
            else if (fn == 'h2A) alu = 4;
            else ill = 1;
        end else if (op == 'h08) begin
            src = 1; rw = 1; dst = ins[20:16];
        end else if (op == 'h0C || op == 'h0D) begin
            alu = (op == 'h0C) ? 2 : 3; src = 1; rw = 1; dst = ins[20:16];
            e.imm = {16'd0, ins[15:0]};
        end else if (op == 'h23) begin
            src = 1; mr = 1; rw = 1; dst = ins[20:16];
        end else if (op == 'h2B) begin
            src = 1; mw = 1;
        end else if (op == 'h04) begin
            alu = 1; br = 1;
        end else begin
            ill = 1;
        end
        if (ill) begin
            alu = 0; src = 0; mr = 0; mw = 0; rw = 0; br = 0; dst = 0;
        end
        if (dst == 0) rw = 0;
        e.valid = 1'b1;
        e.pc4   = pc4;
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.a     = (e.rs == 0) ? 32'd0 : ((we && wa == e.rs) ? wd : r1);
        e.b     = (e.rt == 0) ? 32'd0 : ((we && wa == e.rt) ? wd : r2);
        e.wra   = dst;
        e.ctrl  = {ill, br, mw, mr, rw, src, 3'(alu)};
        return e;
    endfunction

    function automatic logic model_hz(input exp_t cur, input logic v, input logic [31:0] ins);
        logic reads_rt;
        reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        return v && cur.valid && cur.ctrl[5] && (cur.wra != 0) &&
               ((cur.wra == ins[25:21]) || ((cur.wra == ins[20:16]) && reads_rt));
    endfunction

    // Samples stall just before the edge, then advances the model across it.
    task automatic cycle();
        exp_t nx;
        logic hz;
        #1;
        hz = model_hz(mdl, bus.in_valid, bus.in_instr);
        exp_stall  = nrst && hz && !bus.flush;
        stall_seen = bus.stall;
        if (!nrst || bus.flush || hz || !bus.in_valid) nx = '0;
        else nx = model_load(bus.in_instr, bus.in_pc4, bus.rd1, bus.rd2,
                             bus.wb_RegWrite, bus.wb_wra, bus.wb_wrd);
        @(posedge clk);
        mdl = nx;
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc4 = 0; bus.flush = 0;
        bus.rd1 = 0; bus.rd2 = 0; bus.wb_RegWrite = 0; bus.wb_wra = 0; bus.wb_wrd = 0;
    endtask

    task automatic test_reset();
        exp_t got;
        nrst = 0;
        for (int n = 0; n < 3; n++) begin
            bus.in_valid = 1; bus.in_instr = $urandom; bus.in_pc4 = $urandom;
            bus.rd1 = $urandom; bus.rd2 = $urandom; bus.flush = 0;
            cycle();
            got = dut_vec();
            chk_cnt++;
            if (got !== exp_t'(0)) $display("FAIL reset_regs got=%h want=0", got);
            else pass_cnt++;
            chk_cnt++;
            if (stall_seen !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall_seen);
            else pass_cnt++;
        end
    endtask

    task automatic test_addi();
        idle_inputs();
        nrst = 1;
        bus.in_valid = 1; bus.in_instr = 32'h20080005; bus.in_pc4 = 32'h0000_0004;
        cycle();
        chk_cnt++;
        if (bus.ex_valid !== 1'b1) $display("FAIL addi_valid got=%b want=1", bus.ex_valid);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_imm !== 32'd5) $display("FAIL addi_imm got=%h want=5", bus.ex_imm);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_wra !== 5'd8) $display("FAIL addi_wra got=%0d want=8", bus.ex_wra);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_ctrl !== 9'b0_0001_1000) $display("FAIL addi_ctrl got=%b want=000011000", bus.ex_ctrl);
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec() !== mdl) $display("FAIL addi_model got=%h want=%h", dut_vec(), mdl);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        bus.in_valid = 1; bus.in_instr = enc_r(9, 9, 10, 6'h20); bus.in_pc4 = 32'h8;
        bus.rd1 = 0; bus.rd2 = 0;
        bus.wb_RegWrite = 1; bus.wb_wra = 9; bus.wb_wrd = 32'hDEADBEEF;
        cycle();
        chk_cnt++;
        if (bus.ex_a !== 32'hDEADBEEF) $display("FAIL bypass_a got=%h want=deadbeef", bus.ex_a);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_b !== 32'hDEADBEEF) $display("FAIL bypass_b got=%h want=deadbeef", bus.ex_b);
        else pass_cnt++;
        // A WB write to $0 must not leak into an rs=$0 read.
        bus.in_instr = enc_r(0, 9, 10, 6'h20); bus.rd1 = 32'h1234; bus.rd2 = 32'h5678;
        bus.wb_wra = 0; bus.wb_wrd = 32'hFFFF_FFFF;
        cycle();
        chk_cnt++;
        if (bus.ex_a !== 32'd0 || bus.ex_b !== 32'h5678)
            $display("FAIL zero_reg got=%h/%h want=0/5678", bus.ex_a, bus.ex_b);
        else pass_cnt++;
        bus.wb_RegWrite = 0;
    endtask

    task automatic test_load_use();
        bus.in_valid = 1; bus.in_instr = 32'h8C880000; bus.in_pc4 = 32'h10;
        cycle();
        bus.in_instr = enc_r(8, 8, 9, 6'h20); bus.in_pc4 = 32'h14;
        cycle();
        chk_cnt++;
        if (stall_seen !== 1'b1) $display("FAIL lu_stall got=%b want=1", stall_seen);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble got=%b want=0", bus.ex_valid);
        else pass_cnt++;
        cycle();
        chk_cnt++;
        if (stall_seen !== 1'b0) $display("FAIL lu_stall_once got=%b want=0", stall_seen);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd8)
            $display("FAIL lu_add_load got=%b/%0d want=1/8", bus.ex_valid, bus.ex_rs);
        else pass_cnt++;
        bus.in_instr = enc_r(8, 9, 10, 6'h22); bus.in_pc4 = 32'h18;
        cycle();
        chk_cnt++;
        if (stall_seen !== 1'b0 || bus.ex_valid !== 1'b1)
            $display("FAIL lu_second_dep got=%b/%b want=0/1", stall_seen, bus.ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_load_use_flush();
        bus.in_valid = 1; bus.in_instr = 32'h8C880000; bus.in_pc4 = 32'h20;
        cycle();
        bus.in_instr = enc_r(8, 8, 9, 6'h20); bus.flush = 1;
        cycle();
        chk_cnt++;
        if (stall_seen !== 1'b0) $display("FAIL flush_stall got=%b want=0", stall_seen);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 9'd0)
            $display("FAIL flush_bubble got=%b/%b want=0/0", bus.ex_valid, bus.ex_ctrl);
        else pass_cnt++;
        bus.flush = 0; bus.in_valid = 0;
        cycle();
        chk_cnt++;
        if (stall_seen !== 1'b0 || bus.ex_valid !== 1'b0)
            $display("FAIL flush_no_persist got=%b/%b want=0/0", stall_seen, bus.ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        bus.in_valid = 1; bus.in_instr = 32'hFC000000;
        cycle();
        chk_cnt++;
        if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 9'h100 || bus.ex_wra !== 5'd0)
            $display("FAIL illegal_op got=%b/%b/%0d want=1/100000000/0", bus.ex_valid, bus.ex_ctrl, bus.ex_wra);
        else pass_cnt++;
        bus.in_instr = enc_r(1, 2, 3, 6'h3F);
        cycle();
        chk_cnt++;
        if (bus.ex_ctrl !== 9'h100 || bus.ex_wra !== 5'd0)
            $display("FAIL illegal_funct got=%b/%0d want=100000000/0", bus.ex_ctrl, bus.ex_wra);
        else pass_cnt++;
        bus.in_instr = 32'h00220020;
        cycle();
        chk_cnt++;
        if (bus.ex_valid !== 1'b1 || bus.ex_ctrl[4] !== 1'b0 || bus.ex_wra !== 5'd0 || bus.ex_ctrl[8] !== 1'b0)
            $display("FAIL add_r0 got=%b/%b/%0d want=1/0/0", bus.ex_valid, bus.ex_ctrl, bus.ex_wra);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        int k, rs, rt, rd;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
        k  = $urandom_range(0, 8);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        if (k == 0) return enc_r(rs, rt, rd, fns[$urandom_range(0, 5)]);
        if (k == 7) return $urandom;
        if (k == 8) return enc_i(6'h23, rs, rt, 16'($urandom));
        return enc_i(ops[k], rs, rt, 16'($urandom));
    endfunction

    task automatic test_back_to_back();
        exp_t got;
        for (int n = 0; n < 400; n++) begin
            if (!exp_stall) begin
                bus.in_valid = ($urandom_range(0, 7) != 0);
                bus.in_instr = rand_instr();
                bus.in_pc4   = $urandom;
            end
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.rd1 = $urandom; bus.rd2 = $urandom;
            bus.wb_RegWrite = $urandom_range(0, 1);
            bus.wb_wra = 5'($urandom_range(0, 7));
            bus.wb_wrd = $urandom;
            cycle();
            got = dut_vec();
            chk_cnt++;
            if (stall_seen !== exp_stall) $display("FAIL rand_stall n=%0d got=%b want=%b", n, stall_seen, exp_stall);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mdl) $display("FAIL rand_regs n=%0d got=%h want=%h", n, got, mdl);
            else pass_cnt++;
        end
        exp_stall = 0;
    endtask

    task automatic test_async_reset();
        exp_t got;
        idle_inputs();
        bus.in_valid = 1; bus.in_instr = 32'h20080005; bus.in_pc4 = 32'h40;
        cycle();
        chk_cnt++;
        if (bus.ex_valid !== 1'b1) $display("FAIL arst_pre got=%b want=1", bus.ex_valid);
        else pass_cnt++;
        #2 nrst = 0;
        #1;
        mdl = '0;
        got = dut_vec();
        chk_cnt++;
        if (got !== exp_t'(0)) $display("FAIL arst_clear got=%h want=0", got);
        else pass_cnt++;
        #1 nrst = 1;
        cycle();
        chk_cnt++;
        if (dut_vec() !== mdl || bus.ex_valid !== 1'b1)
            $display("FAIL arst_first_load got=%h want=%h", dut_vec(), mdl);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; mdl = '0; exp_stall = 0; stall_seen = 0;
        idle_inputs();
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_load_use_flush();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with the ports named clk and nrst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 nrst  in  1  async active-low reset
 in_valid  in  1  IF/ID holds a valid instruction
 in_instr  in  32  IF/ID instruction word
 in_pc4  in  32  IF/ID PC+4
 flush  in  1  branch/jump taken in EX; squash the ID contents
 rd1  in  32  register file read data for rreg1 (combinational)
 rd2  in  32  register file read data for rreg2 (combinational)
 wb_RegWrite  in  1  WB stage writes the register file this cycle
 wb_wra  in  5  WB write address
 wb_wrd  in  32  WB write data
 rreg1  out  5  equals in_instr[25:21] (rs), combinational
 rreg2  out  5  equals in_instr[20:16] (rt), combinational
 stall  out  1  IF/ID and PC hold this cycle, combinational
 ex_valid  out  1  ID/EX contains a real instruction
 ex_pc4  out  32  registered PC+4
 ex_a  out  32  registered rs operand
 ex_b  out  32  registered rt operand
 ex_imm  out  32  registered extended immediate
 ex_rs  out  5  / ex_rt  out  5  registered source register numbers, used by EX forwarding
 ex_wra  out  5  registered destination register
 ex_ctrl  out  9  registered control bundle {illegal, Branch, MemWrite, MemRead, RegWrite, ALUSrc, ALUOp[2:0]}

Function
REQ-003 The ID/EX register SHALL update on every rising clk edge, giving a latency of 1 cycle from IF/ID to ex_* outputs.
REQ-004 Decode SHALL be as follows:
 - R-type (opcode 0x00), funct 0x20/0x22/0x24/0x25/0x2A → ALUOp ADD=0 / SUB=1 / AND=2 / OR=3 / SLT=4; RegWrite=1; wra=rd.
 - addi 0x08: ADD, ALUSrc=1, sign-extended imm, wra=rt.
 - andi 0x0C and ori 0x0D: AND/OR, ALUSrc=1, zero-extended imm, wra=rt.
 - lw 0x23: ADD, ALUSrc=1, MemRead=1, RegWrite=1, wra=rt.
 - sw 0x2B: ADD, ALUSrc=1, MemWrite=1.
 - beq 0x04: SUB, Branch=1, sign-extended imm.
REQ-005 Any other opcode or funct SHALL set ex_valid=1 and illegal=1, with every other ex_ctrl bit 0 and ex_wra=0.
REQ-006 Any decoded wra of 0 SHALL force RegWrite=0.
REQ-007 Operand selection: ex_a SHALL take 0 if rs==0; otherwise wb_wrd if wb_RegWrite && wb_wra==rs; otherwise rd1. ex_b SHALL follow the same rule with rt and rd2. This gives write-then-read bypass within the same cycle.
REQ-008 Load-use hazard: hz = in_valid && ex_valid && MemRead(ex_ctrl) && ex_wra!=0 && (ex_wra==rs || (ex_wra==rt && the instruction is R-type, sw or beq)).
REQ-009 stall SHALL equal hz && !flush.
REQ-010 A bubble SHALL load ID/EX with ex_valid=0, ex_ctrl=0 and ex_wra=0 (data fields don't-care, but held at 0).
REQ-011 Per edge, with priority flush > hz > normal:
 - flush=1 → bubble;
 - hz=1 → bubble, and IF/ID is held upstream by stall;
 - in_valid=0 → bubble;
 - otherwise → load the decoded instruction.
REQ-012 A flush asserted together with hz SHALL clear stall and squash the instruction; the hazard does not persist.
REQ-013 Two consecutive dependent instructions after a lw SHALL produce exactly one stall cycle.

Reset
REQ-014 While nrst=0, every ex_* register SHALL be 0, ex_valid SHALL be 0, and stall SHALL be 0 regardless of other inputs.
REQ-015 A reset asserted mid-operation SHALL discard ID/EX contents immediately, asynchronously.
REQ-016 The first edge after reset release SHALL load normally.

Structure
REQ-017 Opcode/funct constants, ALUOp encodings and the ex_ctrl bit positions SHALL reside in shared package pipe_pkg, reused by EX and the control logic.
REQ-018 Decode SHALL be sub-module id_decode (combinational: instr → ctrl, wra, imm, uses_rt). Hazard detection, bypass and the ID/EX register SHALL remain in id_ex_stage.

Verification
REQ-019 Reset, then apply addi $t0,$zero,5 (0x20080005) with in_valid=1 → next edge: ex_valid=1, ex_imm=5, ex_wra=8, ALUSrc=1, RegWrite=1, ALUOp=0.
REQ-020 WB writes $9=0xDEADBEEF while ID reads add $10,$9,$9 and rd1=rd2=0 → ex_a=ex_b=0xDEADBEEF.
REQ-021 lw $8,0($4) in EX, then add $9,$8,$8 in ID → stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then the add loads with ex_rs=8.
REQ-022 Same load-use setup with flush=1 → stall=0 and the next ID/EX is a bubble.
REQ-023 Opcode 0x3F, then add $0,$1,$2 → first gives illegal=1, RegWrite=0; second gives RegWrite=0, ex_wra=0.
REQ-024 Drop nrst low mid-stream with ex_valid=1 → ex_valid=0 and all ex_* outputs 0 before the next clk edge.
